// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// Memory handshake: the sequencer raises mem_req (with mem_we / mem_is_fetch
// qualifying it) and holds it steady; the request completes in the cycle where
// mem_ready is 1 while mem_req is 1. mem_ready is ignored while mem_req is 0.
interface mc_ctrl_fsm_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic [2:0]  imm_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic        illegal;
    logic        timeout;
    logic [2:0]  state_o;

    // Sequencer side
    modport master (
        input  instr, mem_ready, br_taken,
        output imm_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we,
               wb_sel, mem_req, mem_we, mem_is_fetch, illegal, timeout, state_o
    );

    // Datapath / memory side
    modport slave (
        output instr, mem_ready, br_taken,
        input  imm_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we,
               wb_sel, mem_req, mem_we, mem_is_fetch, illegal, timeout, state_o
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Controls decode from the current state and the instruction register; the
// mem_ready / br_taken terms only qualify strobes inside the state that waits on them.
// Traps (sticky until reset) on an illegal opcode or a memory wait longer than TIMEOUT_CYC.
module mc_ctrl_fsm #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL
    } cls_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_illegal;
    logic            r_timeout;
    cls_t            w_cls;
    logic [2:0]      w_imm;
    logic            w_wait;
    logic            w_expire;
    logic            w_rd_nz;
    logic            w_unused;

    logic [2:0]      w_imm_sel;
    logic            w_ir_we;
    logic            w_pc_we;
    logic [1:0]      w_pc_sel;
    logic            w_alu_a_sel;
    logic            w_alu_b_sel;
    logic            w_rf_we;
    logic [1:0]      w_wb_sel;
    logic            w_mem_req;
    logic            w_mem_we;
    logic            w_mem_is_fetch;

    // Upper instruction bits belong to the immediate generator, not to control.
    assign w_unused = ^bus.instr[31:15];
    assign w_rd_nz  = (bus.instr[11:7] != 5'd0);

    // Classify the opcode; a full 7-bit match implies instr[1:0] == 2'b11.
    always_comb begin
        w_cls = C_ILL;
        case (bus.instr[6:0])
            7'b0110011: w_cls = C_OP;
            7'b0010011: w_cls = C_OPIMM;
            7'b0000011: w_cls = C_LOAD;
            7'b0100011: w_cls = C_STORE;
            7'b1100011: w_cls = C_BRANCH;
            7'b0110111: w_cls = C_LUI;
            7'b0010111: w_cls = C_AUIPC;
            7'b1101111: w_cls = C_JAL;
            7'b1100111: w_cls = (bus.instr[14:12] == 3'b000) ? C_JALR : C_ILL;
            default:    w_cls = C_ILL;
        endcase
    end

    // Immediate format for the classified instruction.
    always_comb begin
        w_imm = 3'b000;
        case (w_cls)
            C_OPIMM, C_LOAD, C_JALR: w_imm = 3'b001;
            C_STORE:                 w_imm = 3'b010;
            C_BRANCH:                w_imm = 3'b011;
            C_LUI, C_AUIPC:          w_imm = 3'b100;
            C_JAL:                   w_imm = 3'b101;
            default:                 w_imm = 3'b000;
        endcase
    end

    // A memory wait cycle; expiry is the last allowed wait cycle passing without mem_ready.
    assign w_wait   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_expire = w_wait && !bus.mem_ready && (r_cnt == CW'(TIMEOUT_CYC - 1));

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)  w_next = S_DECODE;
                else if (w_expire)  w_next = S_TRAP;
            end
            S_DECODE: w_next = (w_cls == C_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (w_cls == C_BRANCH)                         w_next = S_FETCH;
                else if (w_cls == C_LOAD || w_cls == C_STORE)  w_next = S_MEM;
                else                                           w_next = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready)  w_next = (w_cls == C_STORE) ? S_FETCH : S_WB;
                else if (w_expire)  w_next = S_TRAP;
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // State register, wait counter and sticky trap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && w_cls == C_ILL)
                r_illegal <= 1'b1;
            if (w_expire)
                r_timeout <= 1'b1;
            if (bus.mem_ready || (w_next != r_state))
                r_cnt <= '0;
            else if (w_wait)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    // Control decode from state + instruction; everything forced low during reset.
    always_comb begin
        w_imm_sel      = 3'b000;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = 2'b00;
        w_alu_a_sel    = 1'b0;
        w_alu_b_sel    = 1'b0;
        w_rf_we        = 1'b0;
        w_wb_sel       = 2'b00;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_is_fetch = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req      = 1'b1;
                    w_mem_is_fetch = 1'b1;
                    w_ir_we        = bus.mem_ready;
                end
                S_DECODE: w_imm_sel = w_imm;
                S_EXEC: begin
                    w_imm_sel   = w_imm;
                    w_alu_a_sel = (w_cls == C_AUIPC) || (w_cls == C_JAL) || (w_cls == C_BRANCH);
                    w_alu_b_sel = (w_cls != C_OP);
                    if (w_cls == C_BRANCH) begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = bus.br_taken ? 2'b01 : 2'b00;
                    end
                end
                S_MEM: begin
                    w_imm_sel = w_imm;
                    w_mem_req = 1'b1;
                    w_mem_we  = (w_cls == C_STORE);
                    w_pc_we   = (w_cls == C_STORE) && bus.mem_ready;
                end
                S_WB: begin
                    w_imm_sel = w_imm;
                    w_rf_we   = w_rd_nz;
                    w_pc_we   = 1'b1;
                    case (w_cls)
                        C_LOAD:        w_wb_sel = 2'b01;
                        C_JAL, C_JALR: w_wb_sel = 2'b10;
                        C_LUI:         w_wb_sel = 2'b11;
                        default:       w_wb_sel = 2'b00;
                    endcase
                    case (w_cls)
                        C_JAL:   w_pc_sel = 2'b01;
                        C_JALR:  w_pc_sel = 2'b10;
                        default: w_pc_sel = 2'b00;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.imm_sel      = w_imm_sel;
    assign bus.ir_we        = w_ir_we;
    assign bus.pc_we        = w_pc_we;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.alu_a_sel    = w_alu_a_sel;
    assign bus.alu_b_sel    = w_alu_b_sel;
    assign bus.rf_we        = w_rf_we;
    assign bus.wb_sel       = w_wb_sel;
    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_is_fetch = w_mem_is_fetch;
    assign bus.illegal      = r_illegal & ~rst;
    assign bus.timeout      = r_timeout & ~rst;
    assign bus.state_o      = rst ? 3'd0 : r_state;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for the multi-cycle control FSM. Inputs change 1ns after the
// rising edge; outputs are compared 1ns later, mid-cycle.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Packed view: imm_sel,ir_we,pc_we,pc_sel,alu_a,alu_b,rf_we,wb_sel,mem_req,mem_we,fetch,illegal,timeout,state
  function automatic logic [19:0] ev(input int imm, input int ir, input int pcw, input int pcs,
                                     input int aa, input int ab, input int rf, input int wb,
                                     input int mr, input int mw, input int mf, input int ill,
                                     input int to, input int st);
    return {3'(imm), 1'(ir), 1'(pcw), 2'(pcs), 1'(aa), 1'(ab), 1'(rf), 2'(wb),
            1'(mr), 1'(mw), 1'(mf), 1'(ill), 1'(to), 3'(st)};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.imm_sel, bus.ir_we, bus.pc_we, bus.pc_sel, bus.alu_a_sel, bus.alu_b_sel,
            bus.rf_we, bus.wb_sel, bus.mem_req, bus.mem_we, bus.mem_is_fetch,
            bus.illegal, bus.timeout, bus.state_o};
  endfunction

  task automatic do_rst();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.br_taken = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.instr = 32'h00500093;
    bus.mem_ready = 1'b1;
    bus.br_taken = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs() !== 20'h0) begin
      bad++; $display("FAIL reset_outputs got=%05h exp=%05h", obs(), 20'h0);
    end
    rst = 1'b0;
    #1;
    total++;
    if (obs() !== ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0)) begin
      bad++; $display("FAIL reset_release got=%05h exp=%05h", obs(), ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0));
    end
  endtask

  // FETCH, DECODE, EXEC, WB, then back to FETCH, all with mem_ready=1.
  task automatic test_alu_like(input string name, input logic [31:0] ins, input int imm,
                               input int aa, input int ab, input int rf, input int pcs, input int wb);
    logic [19:0] ex [5];
    do_rst();
    bus.instr = ins;
    bus.mem_ready = 1'b1;
    ex[0] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);
    ex[1] = ev(imm,0,0,0,0,0,0,0,0,0,0,0,0,1);
    ex[2] = ev(imm,0,0,0,aa,ab,0,0,0,0,0,0,0,2);
    ex[3] = ev(imm,0,1,pcs,0,0,rf,wb,0,0,0,0,0,4);
    ex[4] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++; $display("FAIL %s cyc%0d got=%05h exp=%05h", name, i, obs(), ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [19:0] ex [3];
    do_rst();
    bus.instr = 32'h00000463;
    bus.mem_ready = 1'b1;
    ex[0] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);
    ex[1] = ev(3,0,0,0,0,0,0,0,0,0,0,0,0,1);
    ex[2] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++; $display("FAIL beq cyc%0d got=%05h exp=%05h", i, obs(), ex[i]);
      end
      @(posedge clk); #1;
    end
    bus.br_taken = 1'b0;
    #1;
    total++;
    if (obs() !== ev(3,0,1,0,1,1,0,0,0,0,0,0,0,2)) begin
      bad++; $display("FAIL beq_exec_not_taken got=%05h exp=%05h", obs(), ev(3,0,1,0,1,1,0,0,0,0,0,0,0,2));
    end
    bus.br_taken = 1'b1;
    #1;
    total++;
    if (obs() !== ev(3,0,1,1,1,1,0,0,0,0,0,0,0,2)) begin
      bad++; $display("FAIL beq_exec_taken got=%05h exp=%05h", obs(), ev(3,0,1,1,1,1,0,0,0,0,0,0,0,2));
    end
    @(posedge clk); #1;
    #1;
    total++;
    if (obs() !== ex[2]) begin
      bad++; $display("FAIL beq_refetch got=%05h exp=%05h", obs(), ex[2]);
    end
    bus.br_taken = 1'b0;
  endtask

  task automatic test_load();
    logic [19:0] ex [9];
    logic        rdy [9];
    do_rst();
    bus.instr = 32'h0000A103;
    ex[0] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);  rdy[0] = 1'b1;
    ex[1] = ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1);  rdy[1] = 1'b1;
    ex[2] = ev(1,0,0,0,0,1,0,0,0,0,0,0,0,2);  rdy[2] = 1'b1;
    ex[3] = ev(1,0,0,0,0,0,0,0,1,0,0,0,0,3);  rdy[3] = 1'b0;
    ex[4] = ex[3];                            rdy[4] = 1'b0;
    ex[5] = ex[3];                            rdy[5] = 1'b0;
    ex[6] = ex[3];                            rdy[6] = 1'b1;
    ex[7] = ev(1,0,1,0,0,0,1,1,0,0,0,0,0,4);  rdy[7] = 1'b1;
    ex[8] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);  rdy[8] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++; $display("FAIL lw cyc%0d got=%05h exp=%05h", i, obs(), ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [19:0] ex [5];
    do_rst();
    bus.instr = 32'h0020A023;
    bus.mem_ready = 1'b1;
    ex[0] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);
    ex[1] = ev(2,0,0,0,0,0,0,0,0,0,0,0,0,1);
    ex[2] = ev(2,0,0,0,0,1,0,0,0,0,0,0,0,2);
    ex[3] = ev(2,0,1,0,0,0,0,0,1,1,0,0,0,3);
    ex[4] = ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++; $display("FAIL sw cyc%0d got=%05h exp=%05h", i, obs(), ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal(input string name, input logic [31:0] ins);
    do_rst();
    bus.instr = ins;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    #1;
    total++;
    if (obs() !== ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1)) begin
      bad++; $display("FAIL %s decode got=%05h exp=%05h", name, obs(), ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (obs() !== ev(0,0,0,0,0,0,0,0,0,0,0,1,0,7)) begin
        bad++; $display("FAIL %s trap%0d got=%05h exp=%05h", name, i, obs(), ev(0,0,0,0,0,0,0,0,0,0,0,1,0,7));
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs() !== 20'h0) begin
      bad++; $display("FAIL %s rst_in_trap got=%05h exp=%05h", name, obs(), 20'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (obs() !== ev(0,0,0,0,0,0,0,0,1,0,1,0,0,0)) begin
      bad++; $display("FAIL %s after_rst got=%05h exp=%05h", name, obs(), ev(0,0,0,0,0,0,0,0,1,0,1,0,0,0));
    end
  endtask

  task automatic test_timeout();
    do_rst();
    bus.instr = 32'h00500093;
    bus.mem_ready = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      #1;
      total++;
      if (obs() !== ev(0,0,0,0,0,0,0,0,1,0,1,0,0,0)) begin
        bad++; $display("FAIL timeout_wait%0d got=%05h exp=%05h", k, obs(), ev(0,0,0,0,0,0,0,0,1,0,1,0,0,0));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 1);
      #1;
      total++;
      if (obs() !== ev(0,0,0,0,0,0,0,0,0,0,0,0,1,7)) begin
        bad++; $display("FAIL timeout_trap%0d got=%05h exp=%05h", i, obs(), ev(0,0,0,0,0,0,0,0,0,0,0,0,1,7));
      end
      @(posedge clk); #1;
    end
    do_rst();
    bus.mem_ready = 1'b0;
    repeat (63) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (obs() !== ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0)) begin
      bad++; $display("FAIL timeout_edge_ready got=%05h exp=%05h", obs(), ev(0,1,0,0,0,0,0,0,1,0,1,0,0,0));
    end
    @(posedge clk); #1;
    #1;
    total++;
    if (obs() !== ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1)) begin
      bad++; $display("FAIL timeout_edge_decode got=%05h exp=%05h", obs(), ev(1,0,0,0,0,0,0,0,0,0,0,0,0,1));
    end
  endtask

  task automatic test_mid_reset();
    do_rst();
    bus.instr = 32'h0000A103;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (obs() !== ev(1,0,0,0,0,0,0,0,1,0,0,0,0,3)) begin
      bad++; $display("FAIL midrst_mem got=%05h exp=%05h", obs(), ev(1,0,0,0,0,0,0,0,1,0,0,0,0,3));
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs() !== 20'h0) begin
      bad++; $display("FAIL midrst_abort got=%05h exp=%05h", obs(), 20'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (obs() !== ev(0,0,0,0,0,0,0,0,1,0,1,0,0,0)) begin
      bad++; $display("FAIL midrst_restart got=%05h exp=%05h", obs(), ev(0,0,0,0,0,0,0,0,1,0,1,0,0,0));
    end
  endtask

  initial begin
    bus.instr = 32'h0;
    bus.mem_ready = 1'b0;
    bus.br_taken = 1'b0;
    test_reset();
    test_alu_like("addi",  32'h00500093, 1, 0, 1, 1, 0, 0);
    test_alu_like("add",   32'h002081B3, 0, 0, 0, 1, 0, 0);
    test_alu_like("auipc", 32'h00001297, 4, 1, 1, 1, 0, 0);
    test_alu_like("lui_x0", 32'h12345037, 4, 0, 1, 0, 0, 3);
    test_alu_like("jal",   32'h008000EF, 5, 1, 1, 1, 1, 2);
    test_alu_like("jalr",  32'h000080E7, 1, 0, 1, 1, 2, 2);
    test_branch();
    test_load();
    test_store();
    test_illegal("ill_ones", 32'hFFFFFFFF);
    test_illegal("ill_jalr_f3", 32'h000090E7);
    test_illegal("ill_low_bits", 32'h00000010);
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
